mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- CPU-side initiator for the Memory block.
- Accepts one load/store request at a time over a valid/ready handshake.
- Aligned requests drive Memory's address/data/writeMode/readMode/unsignedLoad for exactly one cycle.
- Misaligned requests are split into serial BYTE accesses, or faulted when the optional feature is disabled. Responses return through a registered valid/ready channel.

Parameters:
- MEM_BYTES, 65536, byte size of the addressable memory; the highest legal byte address is MEM_BYTES-1.
- ADDR_W, 32, address and data width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  3  MemoryModes value; only BYTE, HALFWORD and WORD are legal
- req_unsigned  in  1  zero-extend a load (1) or sign-extend it (0)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  32  load result, extended per req_unsigned; 0 for stores and faults
- resp_fault  out  1  request rejected; no memory access was made
- address  out  32  to Memory
- data  out  32  to Memory
- writeMode  out  3  to Memory
- readMode  out  3  to Memory
- unsignedLoad  out  1  to Memory
- dataOutput  in  32  from Memory; combinational read data

Behaviour:
- Memory contract:
  - Writes commit on the rising edge of clk while writeMode != NONE.
  - Reads are combinational and are sampled at the end of the access cycle.
  - Memory is little-endian: the byte at addr+0 is data bits [7:0].
- Reset values:
  - State IDLE; req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_fault=0.
  - address=0, data=0, writeMode=NONE, readMode=NONE, unsignedLoad=0.
- Idle Memory outputs: outside ACCESS and SPLIT, writeMode and readMode are NONE and address/data are 0.
- Request legality:
  - N = 1, 2 or 4 bytes for BYTE, HALFWORD or WORD.
  - Aligned means addr mod N == 0.
  - Out of range means addr+N-1 >= MEM_BYTES. The sum is computed 33 bits wide so that 32-bit wrap is also out of range.
  - An illegal req_size, out-of-range address, or misaligned address with the split feature disabled produces a fault.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields.
  - Aligned and in range: go to ACCESS.
  - Misaligned, in range, and split enabled: go to SPLIT with k=0.
  - Otherwise: go to RESP with fault=1.
- ACCESS (one cycle):
  - Drive address=addr and readMode or writeMode = size.
  - data = wdata for a store, 0 for a load.
  - unsignedLoad = req_unsigned.
  - A load captures dataOutput unchanged.
  - Go to RESP.
- SPLIT (N cycles, k = 0..N-1):
  - Drive address=addr+k with mode BYTE.
  - Store: data = {24'b0, wdata[8k+7:8k]}.
  - Load: unsignedLoad=1; capture dataOutput[7:0] into buf[8k+7:8k].
  - After k=N-1, go to RESP. A load extends buf from bit 8N-1 according to req_unsigned.
- RESP:
  - resp_valid=1; resp_rdata and resp_fault are held stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE with resp_valid=0.
  - req_ready=0 in every state except IDLE.
- Latency (request accepted at edge T):
  - Aligned: access cycle T..T+1, resp_valid from T+1.
  - Split: resp_valid from T+N.
  - Fault: resp_valid from T+1.
- Stores: the response carries rdata=0 and fault=0.
- Reset mid-operation:
  - Returns immediately to reset values; Memory modes go to NONE asynchronously.
  - Bytes already committed by a split store are not rolled back.
  - No response is generated for the aborted request.

Optional Feature:
- Macro MEM_ACCESS_SPLIT_EN.
- Defined: misaligned in-range requests execute as N serial BYTE accesses (SPLIT state present).
- Undefined: SPLIT state and byte counter are not compiled; every misaligned request faults with zero Memory activity.

Decomposition:
- Use the existing MemoryModes package for the mode enum (NONE, BYTE, HALFWORD, WORD, WORDLEFT).
- Add to that package:
  - an access-state enum (IDLE, ACCESS, SPLIT, RESP);
  - a function returning N for a mode.
- One sub-module, mem_access_extend: combinational zero/sign extension of an N-byte value to 32 bits, shared by the split path.

Test Plan:
- Store WORD 0x22345678 @65532, then load WORD @65532 -> rdata 0x22345678, fault 0; exactly one Memory write cycle observed.
- Store HALFWORD 0xFFFF @65528; load HALFWORD signed -> 0xFFFFFFFF; load unsigned -> 0x0000FFFF.
- (SPLIT_EN) Store WORD 0xA1B2C3D4 @65525:
  - four BYTE writes at 65525..65528 with data D4, C3, B2, A1;
  - load WORD @65525 -> 0xA1B2C3D4, resp_valid 4 cycles after accept;
  - load HALFWORD signed @65527 -> 0xFFFFA1B2.
- (no SPLIT_EN) Load WORD @65530 -> resp_fault=1, rdata 0, writeMode and readMode stay NONE throughout.
- Load WORD @65534, or BYTE @65536 -> fault; req_size=WORDLEFT -> fault.
- Hold resp_ready=0 for 3 cycles: resp_valid, rdata and req_ready=0 are stable. Assert rst mid-SPLIT: next edge shows IDLE, req_ready=1, modes NONE.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access unit: Memory mode encoding, access FSM
// states and the byte-count helper used for legality checks.
package mem_access_unit_pkg;

   typedef enum logic [2:0] {
      NONE     = 3'd0,
      BYTE     = 3'd1,
      HALFWORD = 3'd2,
      WORD     = 3'd3,
      WORDLEFT = 3'd4
   } memory_modes_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      SPLIT  = 2'd2,
      RESP   = 2'd3
   } acc_state_e;

   // Bytes touched by a mode; 0 marks a mode the unit does not accept.
   function automatic logic [2:0] mode_bytes(input memory_modes_e m);
      case (m)
         BYTE:     mode_bytes = 3'd1;
         HALFWORD: mode_bytes = 3'd2;
         WORD:     mode_bytes = 3'd4;
         default:  mode_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_extend.sv
// Zero/sign extension of a right-justified 1-, 2- or 4-byte value to W bits.
module mem_access_extend #(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic [2:0]   nbytes_i,
   input  logic         uns_i,
   output logic [W-1:0] ext_o
);

   always_comb begin
      ext_o = val_i;
      case (nbytes_i)
         3'd1:    ext_o = {{(W-8){~uns_i & val_i[7]}}, val_i[7:0]};
         3'd2:    ext_o = {{(W-16){~uns_i & val_i[15]}}, val_i[15:0]};
         default: ext_o = val_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator for Memory: one request at a time, registered response.
// Define MEM_ACCESS_SPLIT_EN to run misaligned requests as serial BYTE accesses.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int MEM_BYTES = 65536,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [ADDR_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [ADDR_W-1:0] resp_rdata,
   output logic              resp_fault,
   output logic [ADDR_W-1:0] address,
   output logic [ADDR_W-1:0] data,
   output logic [2:0]        writeMode,
   output logic [2:0]        readMode,
   output logic              unsignedLoad,
   input  logic [ADDR_W-1:0] dataOutput
);

   acc_state_e    state_q, state_d;
   logic          write_q, write_d;
   memory_modes_e size_q, size_d;
   logic          uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W-1:0] rdata_q, rdata_d;
   logic          fault_q, fault_d;

   logic [2:0]    req_n;
   logic [ADDR_W:0] req_last;
   logic          size_ok, in_range, misalign;

   // Last byte address is formed one bit wider so a 32-bit wrap reads as out of range.
   always_comb begin
      req_n    = mode_bytes(memory_modes_e'(req_size));
      req_last = {1'b0, req_addr} + (ADDR_W+1)'(req_n) - (ADDR_W+1)'(1);
      size_ok  = req_n != 3'd0;
      in_range = req_last < (ADDR_W+1)'(MEM_BYTES);
      case (req_n)
         3'd2:    misalign = req_addr[0];
         3'd4:    misalign = |req_addr[1:0];
         default: misalign = 1'b0;
      endcase
   end

`ifdef MEM_ACCESS_SPLIT_EN
   logic [1:0]        k_q, k_d;
   logic [ADDR_W-1:0] buf_q, buf_d;
   logic [ADDR_W-1:0] split_word, split_ext;
   logic [2:0]        cur_n;
   logic              last_byte;

   assign cur_n      = mode_bytes(size_q);
   assign last_byte  = k_q == 2'(cur_n - 3'd1);
   assign split_word = buf_q | (ADDR_W'(dataOutput[7:0]) << {k_q, 3'b000});

   mem_access_extend #(.W(ADDR_W)) u_extend (
      .val_i    (split_word),
      .nbytes_i (cur_n),
      .uns_i    (uns_q),
      .ext_o    (split_ext)
   );
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         size_q  <= NONE;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
`ifdef MEM_ACCESS_SPLIT_EN
         k_q     <= 2'd0;
         buf_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
`ifdef MEM_ACCESS_SPLIT_EN
         k_q     <= k_d;
         buf_q   <= buf_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
`ifdef MEM_ACCESS_SPLIT_EN
      k_d     = k_q;
      buf_d   = buf_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               size_d  = memory_modes_e'(req_size);
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rdata_d = '0;
               fault_d = 1'b0;
`ifdef MEM_ACCESS_SPLIT_EN
               k_d     = 2'd0;
               buf_d   = '0;
`endif
               if (size_ok && in_range && !misalign) begin
                  state_d = ACCESS;
`ifdef MEM_ACCESS_SPLIT_EN
               end else if (size_ok && in_range) begin
                  state_d = SPLIT;
`endif
               end else begin
                  state_d = RESP;
                  fault_d = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (!write_q) rdata_d = dataOutput;
            state_d = RESP;
         end
`ifdef MEM_ACCESS_SPLIT_EN
         SPLIT: begin
            buf_d = split_word;
            k_d   = k_q + 2'd1;
            if (last_byte) begin
               state_d = RESP;
               rdata_d = write_q ? '0 : split_ext;
            end
         end
`endif
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory-side signals decode straight from state so reset idles Memory at once.
   always_comb begin
      req_ready    = state_q == IDLE;
      resp_valid   = state_q == RESP;
      resp_rdata   = rdata_q;
      resp_fault   = fault_q;
      address      = '0;
      data         = '0;
      writeMode    = NONE;
      readMode     = NONE;
      unsignedLoad = 1'b0;
      case (state_q)
         ACCESS: begin
            address      = addr_q;
            unsignedLoad = uns_q;
            if (write_q) begin
               writeMode = size_q;
               data      = wdata_q;
            end else begin
               readMode  = size_q;
            end
         end
`ifdef MEM_ACCESS_SPLIT_EN
         SPLIT: begin
            address = addr_q + ADDR_W'(k_q);
            if (write_q) begin
               writeMode = BYTE;
               data      = {{(ADDR_W-8){1'b0}}, 8'(wdata_q >> {k_q, 3'b000})};
            end else begin
               readMode     = BYTE;
               unsignedLoad = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array Memory model, request-level reference
// model, directed cases plus randomized traffic. Honours MEM_ACCESS_SPLIT_EN.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int MEM_BYTES = 65536;
`ifdef MEM_ACCESS_SPLIT_EN
   localparam bit SPLIT_ON = 1'b1;
`else
   localparam bit SPLIT_ON = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
   logic [2:0]  req_size = 3'd0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        resp_valid, resp_ready = 1'b0, resp_fault;
   logic [31:0] resp_rdata, address, data, dataOutput = '0;
   logic [2:0]  writeMode, readMode;
   logic        unsignedLoad;

   int total = 0, bad = 0;
   int wr_cnt = 0, act_cnt = 0;
   bit [7:0] mem [MEM_BYTES];
   bit [7:0] ref_mem [MEM_BYTES];
   logic [47:0] wlog [$];

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .address(address), .data(data), .writeMode(writeMode), .readMode(readMode),
      .unsignedLoad(unsignedLoad), .dataOutput(dataOutput)
   );

   function automatic int nbytes(input logic [2:0] m);
      case (m)
         3'd1: return 1;
         3'd2: return 2;
         3'd3: return 4;
         default: return 0;
      endcase
   endfunction

   // Memory: commits on the rising edge, read data settled before the next edge.
   always @(posedge clk) begin
      if (writeMode != 3'd0 || readMode != 3'd0) act_cnt++;
      if (writeMode != 3'd0) begin
         wr_cnt++;
         wlog.push_back({writeMode, 5'd0, address[15:0], data[23:0]});
         for (int i = 0; i < nbytes(writeMode); i++)
            mem[16'(address + 32'(i))] = data[8*i +: 8];
      end
   end

   always @(negedge clk) begin
      longint v;
      int n;
      n = nbytes(readMode);
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(mem[16'(address + 32'(i))]) << (8*i));
      if (n != 0 && !unsignedLoad && v[8*n-1]) v = v | ~((longint'(1) << (8*n)) - 1);
      dataOutput = 32'(v);
   end

   // Reference: outcome of a whole request from the addressing rules alone.
   function automatic bit ref_fault(input logic [2:0] s, input logic [31:0] a);
      int n = nbytes(s);
      if (n == 0) return 1'b1;
      if (longint'(a) + n - 1 >= MEM_BYTES) return 1'b1;
      if ((a % n) != 0 && !SPLIT_ON) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] s, input logic u, input logic [31:0] a);
      int n = nbytes(s);
      longint v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[a + 32'(i)]) << (8*i));
      if (!u && v[8*n-1]) v = v | ~((longint'(1) << (8*n)) - 1);
      return 32'(v);
   endfunction

   function automatic int ref_lat(input logic [2:0] s, input logic [31:0] a);
      if (ref_fault(s, a)) return 1;
      if ((a % nbytes(s)) != 0) return nbytes(s);
      return 1;
   endfunction

   task automatic do_req(input logic w, input logic [2:0] s, input logic u, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic flt, output int lat);
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_idle got=%b want=1", req_ready); end
      req_valid = 1'b1; req_write = w; req_size = s; req_unsigned = u; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      rd = 'x; flt = 1'bx;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (resp_valid === 1'b1) break;
      end
      if (resp_valid !== 1'b1) begin
         total++; bad++;
         $display("FAIL resp_timeout addr=%h size=%0d", a, s);
         return;
      end
      rd = resp_rdata; flt = resp_fault;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      if (!w && !ref_fault(s, a)) ; // loads leave ref_mem untouched
      if (w && !ref_fault(s, a))
         for (int i = 0; i < nbytes(s); i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      total++;
      if ({req_ready, resp_valid, resp_fault, unsignedLoad} !== 4'b1000 || resp_rdata !== 32'd0) begin
         bad++; $display("FAIL reset_handshake got=%b%b%b%b rdata=%h want=1000 rdata=0",
                         req_ready, resp_valid, resp_fault, unsignedLoad, resp_rdata);
      end
      total++;
      if (address !== 32'd0 || data !== 32'd0 || writeMode !== 3'd0 || readMode !== 3'd0) begin
         bad++; $display("FAIL reset_memory addr=%h data=%h wm=%0d rm=%0d want all 0", address, data, writeMode, readMode);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_aligned();
      logic [31:0] rd; logic f; int lat, w0;
      w0 = wr_cnt;
      do_req(1'b1, WORD, 1'b0, 32'd65532, 32'h22345678, rd, f, lat);
      total++;
      if (rd !== 32'd0 || f !== 1'b0 || lat != 1) begin bad++; $display("FAIL store_word got rd=%h f=%b lat=%0d want 0 0 1", rd, f, lat); end
      total++;
      if (wr_cnt - w0 != 1) begin bad++; $display("FAIL store_word_writes got=%0d want=1", wr_cnt - w0); end
      do_req(1'b0, WORD, 1'b0, 32'd65532, 32'd0, rd, f, lat);
      total++;
      if (rd !== 32'h22345678 || f !== 1'b0 || lat != 1) begin bad++; $display("FAIL load_word got rd=%h f=%b lat=%0d want 22345678 0 1", rd, f, lat); end
      do_req(1'b1, HALFWORD, 1'b0, 32'd65528, 32'h0000FFFF, rd, f, lat);
      do_req(1'b0, HALFWORD, 1'b0, 32'd65528, 32'd0, rd, f, lat);
      total++;
      if (rd !== 32'hFFFFFFFF || f !== 1'b0) begin bad++; $display("FAIL load_half_signed got=%h want=ffffffff", rd); end
      do_req(1'b0, HALFWORD, 1'b1, 32'd65528, 32'd0, rd, f, lat);
      total++;
      if (rd !== 32'h0000FFFF || f !== 1'b0) begin bad++; $display("FAIL load_half_unsigned got=%h want=0000ffff", rd); end
   endtask

   task automatic test_misaligned();
      logic [31:0] rd; logic f; int lat, a0;
`ifdef MEM_ACCESS_SPLIT_EN
      logic [47:0] e;
      wlog.delete();
      do_req(1'b1, WORD, 1'b0, 32'd65525, 32'hA1B2C3D4, rd, f, lat);
      total++;
      if (f !== 1'b0 || rd !== 32'd0 || lat != 4) begin bad++; $display("FAIL split_store got f=%b rd=%h lat=%0d want 0 0 4", f, rd, lat); end
      total++;
      if (wlog.size() != 4) begin bad++; $display("FAIL split_store_count got=%0d want=4", wlog.size()); end
      for (int i = 0; i < 4 && i < wlog.size(); i++) begin
         e = {BYTE, 5'd0, 16'(65525 + i), 16'd0, 8'(32'hA1B2C3D4 >> (8*i))};
         total++;
         if (wlog[i] !== e) begin bad++; $display("FAIL split_store_byte%0d got=%h want=%h", i, wlog[i], e); end
      end
      do_req(1'b0, WORD, 1'b0, 32'd65525, 32'd0, rd, f, lat);
      total++;
      if (rd !== 32'hA1B2C3D4 || f !== 1'b0 || lat != 4) begin bad++; $display("FAIL split_load_word got rd=%h lat=%0d want a1b2c3d4 4", rd, lat); end
      do_req(1'b0, HALFWORD, 1'b0, 32'd65527, 32'd0, rd, f, lat);
      total++;
      if (rd !== 32'hFFFFA1B2 || f !== 1'b0 || lat != 2) begin bad++; $display("FAIL split_load_half got rd=%h lat=%0d want ffffa1b2 2", rd, lat); end
`else
      a0 = act_cnt;
      do_req(1'b0, WORD, 1'b0, 32'd65530, 32'd0, rd, f, lat);
      total++;
      if (f !== 1'b1 || rd !== 32'd0 || lat != 1) begin bad++; $display("FAIL misalign_fault got f=%b rd=%h lat=%0d want 1 0 1", f, rd, lat); end
      total++;
      if (act_cnt != a0) begin bad++; $display("FAIL misalign_no_access got=%0d want=0", act_cnt - a0); end
`endif
   endtask

   task automatic test_range();
      logic [31:0] rd; logic f; int lat, a0;
      a0 = act_cnt;
      do_req(1'b0, WORD, 1'b0, 32'd65534, 32'd0, rd, f, lat);
      total++;
      if (f !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL range_word got f=%b rd=%h want 1 0", f, rd); end
      do_req(1'b1, BYTE, 1'b0, 32'd65536, 32'h55, rd, f, lat);
      total++;
      if (f !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL range_byte got f=%b rd=%h want 1 0", f, rd); end
      do_req(1'b0, WORD, 1'b0, 32'hFFFFFFFC, 32'd0, rd, f, lat);
      total++;
      if (f !== 1'b1) begin bad++; $display("FAIL range_wrap got f=%b want 1", f); end
      do_req(1'b0, WORDLEFT, 1'b0, 32'd0, 32'd0, rd, f, lat);
      total++;
      if (f !== 1'b1 || rd !== 32'd0 || lat != 1) begin bad++; $display("FAIL size_wordleft got f=%b lat=%0d want 1 1", f, lat); end
      total++;
      if (act_cnt != a0) begin bad++; $display("FAIL fault_no_access got=%0d want=0", act_cnt - a0); end
   endtask

   task automatic test_random();
      logic [31:0] rd, a, wd, er; logic f, w, u; logic [2:0] s; int lat, sel, ef, el;
      for (int it = 0; it < 80; it++) begin
         sel = $urandom_range(0, 9);
         s = (sel < 3) ? BYTE : (sel < 6) ? HALFWORD : (sel < 9) ? WORD : 3'($urandom_range(4, 7));
         sel = $urandom_range(0, 9);
         a = (sel < 6) ? 32'(65500 + $urandom_range(0, 40)) : (sel < 9) ? 32'($urandom_range(0, 64)) : 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
         if (sel == 5 && s == 3'd0) s = BYTE;
         w = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1)); wd = $urandom;
         ef = ref_fault(s, a);
         el = ref_lat(s, a);
         er = (w || ef) ? 32'd0 : ref_load(s, u, a);
         do_req(w, s, u, a, wd, rd, f, lat);
         total++;
         if (rd !== er || f !== 1'(ef) || lat != el) begin
            bad++;
            $display("FAIL rand%0d w=%b s=%0d u=%b a=%h got rd=%h f=%b lat=%0d want rd=%h f=%0d lat=%0d",
                     it, w, s, u, a, rd, f, lat, er, ef, el);
         end
      end
   endtask

   task automatic test_resp_hold();
      logic [31:0] er; int n;
      er = ref_load(WORD, 1'b0, 32'd65532);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = WORD; req_unsigned = 1'b0; req_addr = 32'd65532;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      for (int c = 0; c < 3; c++) begin
         total++;
         if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== er || resp_fault !== 1'b0) begin
            bad++; $display("FAIL resp_hold%0d got v=%b rr=%b rd=%h want 1 0 %h", c, resp_valid, req_ready, resp_rdata, er);
         end
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      total++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL resp_release got v=%b rr=%b want 0 1", resp_valid, req_ready); end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] rd; logic f; int lat;
      @(negedge clk);
`ifdef MEM_ACCESS_SPLIT_EN
      req_valid = 1'b1; req_write = 1'b1; req_size = WORD; req_addr = 32'd65521; req_wdata = 32'h11223344;
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk); #1;
`else
      req_valid = 1'b1; req_write = 1'b1; req_size = WORD; req_addr = 32'd100; req_wdata = 32'h11223344;
      @(posedge clk); #1; req_valid = 1'b0;
`endif
      rst = 1'b1;
      #1;
      total++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || writeMode !== 3'd0 || readMode !== 3'd0 || address !== 32'd0) begin
         bad++; $display("FAIL reset_async got rr=%b v=%b wm=%0d rm=%0d a=%h", req_ready, resp_valid, writeMode, readMode, address);
      end
      @(posedge clk); #1;
      total++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || writeMode !== 3'd0) begin
         bad++; $display("FAIL reset_edge got rr=%b v=%b wm=%0d", req_ready, resp_valid, writeMode);
      end
      @(negedge clk); rst = 1'b0;
      do_req(1'b0, WORD, 1'b0, 32'd100, 32'd0, rd, f, lat);
      total++;
      if (rd !== ref_load(WORD, 1'b0, 32'd100) || f !== 1'b0) begin
         bad++; $display("FAIL after_reset_load got=%h want=%h", rd, ref_load(WORD, 1'b0, 32'd100));
      end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_misaligned();
      test_range();
      test_random();
      test_resp_hold();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
